// File: rtl/multi_rate_bit_encoder_pkg.sv
// ============================================================================
// Module : iso14443a_enc_pkg
// Brief  : Shared types and helpers for the multi-rate PICC bit encoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package iso14443a_enc_pkg;

  typedef enum logic [1:0] {
    BR_106 = 2'd0,
    BR_212 = 2'd1,
    BR_424 = 2'd2,
    BR_848 = 2'd3
  } bit_rate_t;

  typedef enum logic {
    ENC_MANCHESTER = 1'b0,
    ENC_BPSK       = 1'b1
  } enc_mode_t;

  // Each rate step halves the number of carrier ticks per bit.
  function automatic int unsigned bit_period(input int unsigned max_ticks,
                                             input bit_rate_t   r);
    return max_ticks >> r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_rate_bit_encoder_if.sv
// ============================================================================
// Module : multi_rate_bit_encoder_if
// Brief  : Control, handshake and line-output bundle of the bit encoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface multi_rate_bit_encoder_if;

  logic       en;
  logic [1:0] rate;
  logic       mode;
  logic       data;
  logic       data_valid;
  logic       data_ready;
  logic       encoded_data;
  logic       lm_out;
  logic       last_tick;
  logic       underrun;
  logic       busy;

  modport master (
    output en, rate, mode, data, data_valid,
    input  data_ready, encoded_data, lm_out, last_tick, underrun, busy
  );

  modport slave (
    input  en, rate, mode, data, data_valid,
    output data_ready, encoded_data, lm_out, last_tick, underrun, busy
  );

endinterface

`default_nettype wire

// File: rtl/multi_rate_bit_encoder_bit_period_counter.sv
// ============================================================================
// Module : bit_period_counter
// Brief  : Tick counter over one bit period with start/last/half/subcarrier strobes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bit_period_counter
  import iso14443a_enc_pkg::*;
#(
  parameter int unsigned MAX_BIT_TICKS = 128,
  parameter int unsigned SC_DIV        = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_en,
  input  bit_rate_t i_rate,
  output logic      o_start,
  output logic      o_last_tick,
  output logic      o_second_half,
  output logic      o_sc
);

  localparam int unsigned c_CW     = $clog2(MAX_BIT_TICKS);
  localparam int unsigned c_SC_MSB = $clog2(SC_DIV) - 1;

  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] w_last_cnt;
  logic [c_CW-1:0] w_half_cnt;
  logic            w_wrap;

  assign w_last_cnt = c_CW'(bit_period(MAX_BIT_TICKS, i_rate) - 1);
  assign w_half_cnt = c_CW'(bit_period(MAX_BIT_TICKS, i_rate) >> 1);
  assign w_wrap     = (r_count == w_last_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_en || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_CW'(1);
    end
  end

  assign o_start       = i_en && (r_count == '0);
  assign o_last_tick   = i_en && w_wrap;
  assign o_second_half = (r_count >= w_half_cnt);
  // Periods are whole multiples of SC_DIV, so this bit gives a bit-aligned subcarrier.
  assign o_sc          = ~r_count[c_SC_MSB];

endmodule

`default_nettype wire

// File: rtl/multi_rate_bit_encoder.sv
// ============================================================================
// Module : multi_rate_bit_encoder
// Brief  : Multi-rate Manchester/BPSK PICC bit encoder with subcarrier load modulation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multi_rate_bit_encoder
  import iso14443a_enc_pkg::*;
#(
  parameter int unsigned MAX_BIT_TICKS = 128,
  parameter int unsigned SC_DIV        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multi_rate_bit_encoder_if.slave   bus
);

  bit_rate_t r_rate;
  enc_mode_t r_mode;
  logic      r_hold;
  logic      r_hold_full;
  logic      r_cur_bit;
  logic      r_idle;
  logic      r_enc;
  logic      r_lm;

  logic      w_start;
  logic      w_last_tick;
  logic      w_second_half;
  logic      w_sc;
  logic      w_bit;
  logic      w_idle;
  logic      w_enc;
  logic      w_lm;

  bit_period_counter #(
    .MAX_BIT_TICKS (MAX_BIT_TICKS),
    .SC_DIV        (SC_DIV)
  ) u_counter (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (bus.en),
    .i_rate        (r_rate),
    .o_start       (w_start),
    .o_last_tick   (w_last_tick),
    .o_second_half (w_second_half),
    .o_sc          (w_sc)
  );

  // Configuration only tracks the inputs while idle; a running stream keeps its rate/mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate <= BR_106;
      r_mode <= ENC_MANCHESTER;
    end else if (!bus.en) begin
      r_rate <= bit_rate_t'(bus.rate);
      r_mode <= enc_mode_t'(bus.mode);
    end
  end

  // Consume and accept are exclusive: a consume only happens while the register is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= 1'b0;
      r_hold_full <= 1'b0;
      r_cur_bit   <= 1'b0;
      r_idle      <= 1'b1;
    end else begin
      if (w_start) begin
        r_idle <= !r_hold_full;
      end
      if (w_start && r_hold_full) begin
        r_cur_bit   <= r_hold;
        r_hold_full <= 1'b0;
      end else if (bus.data_valid && !r_hold_full) begin
        r_hold      <= bus.data;
        r_hold_full <= 1'b1;
      end
    end
  end

  // Tick 0 must already use the bit being loaded this cycle.
  always_comb begin
    w_bit  = w_start ? r_hold : r_cur_bit;
    w_idle = w_start ? !r_hold_full : r_idle;
    w_enc  = 1'b0;
    w_lm   = 1'b0;
    if (!w_idle) begin
      if (r_mode == ENC_BPSK) begin
        w_enc = w_bit;
        w_lm  = w_bit ? w_sc : !w_sc;
      end else begin
        w_enc = w_second_half ? !w_bit : w_bit;
        w_lm  = w_enc & w_sc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc <= 1'b0;
      r_lm  <= 1'b0;
    end else if (!bus.en) begin
      r_enc <= 1'b0;
      r_lm  <= 1'b0;
    end else begin
      r_enc <= w_enc;
      r_lm  <= w_lm;
    end
  end

  assign bus.data_ready   = !r_hold_full;
  assign bus.encoded_data = r_enc;
  assign bus.lm_out       = r_lm;
  assign bus.last_tick    = w_last_tick;
  assign bus.underrun     = w_start && !r_hold_full;
  assign bus.busy         = bus.en;

endmodule

`default_nettype wire

// File: doc/multi_rate_bit_encoder.md
Name: multi_rate_bit_encoder

Overview:
Next-generation PICC-to-PCD bit encoder. It adds selectable bit rates (106/212/424/848 kbit/s), Manchester or BPSK coding, on-chip subcarrier load-modulation output, and a valid/ready input handshake with a one-bit holding register and underrun detection. It sits between the frame serialiser and the analogue load-modulation driver, clocked from the 13.56 MHz carrier clock.

Parameters:
MAX_BIT_TICKS, 128, ticks per bit at rate 0 (106 kbit/s); power of two; MAX_BIT_TICKS>>3 >= SC_DIV
SC_DIV, 16, subcarrier period in ticks (fc/16); power of two, >= 2

Ports:
clk  input  1  13.56 MHz carrier clock
rst_n  input  1  active-low reset, asserted asynchronously, deasserted synchronously to clk
en  input  1  encoder enable; a high level runs back-to-back bit periods
rate  input  2  bit rate select: 0=106k, 1=212k, 2=424k, 3=848k
mode  input  1  0=Manchester, 1=BPSK
data  input  1  bit to send
data_valid  input  1  data is valid
data_ready  output  1  holding register empty, so data is accepted
encoded_data  output  1  baseband coded bit stream
lm_out  output  1  subcarrier-modulated load-modulation drive
last_tick  output  1  final tick of the current bit period
underrun  output  1  one-cycle pulse: no bit available at the start of a bit period
busy  output  1  equals en

Behaviour:
- Bit period P = MAX_BIT_TICKS >> rate, giving 128/64/32/16 with defaults. Counter width is $clog2(MAX_BIT_TICKS). Counter runs 0..P-1 and wraps to 0 while en is high. It holds at 0 while en is low.
- rate and mode are latched on every cycle while en is low. Changes while en is high are ignored until en next falls.
- Holding register hold/hold_full:
  - data_ready = !hold_full.
  - Accept when data_valid && data_ready. hold_full sets on the next cycle.
  - Loading is legal while en is low (preload). Contents persist across en low.
- Bit-period start (en && count==0):
  - If hold_full: cur_bit <= hold and hold_full <= 0. data_ready rises on the next cycle.
  - Otherwise: underrun pulses high this cycle and the period is an idle period.
  - There is no bypass. A bit offered while data_ready=1 in the count==0 cycle is written to hold and used at the next period start, not this one.
- Output timing: encoded_data and lm_out are registered. The values for tick k appear in the cycle after count==k.
- Subcarrier sc(k) = 1 when (k mod SC_DIV) < SC_DIV/2. It is phase-aligned to every bit start.
- Manchester mode:
  - encoded_data = cur_bit for ticks 0..P/2-1, then !cur_bit for ticks P/2..P-1.
  - lm_out = encoded_data AND sc(k).
- BPSK mode:
  - encoded_data = cur_bit for the whole period.
  - lm_out = sc(k) when cur_bit=1, !sc(k) when cur_bit=0.
- Idle (underrun) period: encoded_data=0 and lm_out=0 for all ticks.
- last_tick = en && count==P-1. It is combinational, and so is underrun.
- en falls mid-bit: the current bit is dropped and the counter returns to 0. encoded_data and lm_out are 0 from the next cycle. hold is kept.
- en low: encoded_data=0, lm_out=0, underrun=0, last_tick=0.
- Reset values: count=0, hold_full=0, cur_bit=0, encoded_data=0, lm_out=0, latched rate=0, latched mode=0. Hence data_ready=1, underrun=0, last_tick=0, busy=en.

Decomposition:
- Package iso14443a_enc_pkg:
  - enum bit_rate_t {BR_106, BR_212, BR_424, BR_848}
  - enum enc_mode_t {ENC_MANCHESTER, ENC_BPSK}
  - function bit_period(MAX_BIT_TICKS, bit_rate_t)
- Sub-module bit_period_counter: counter, wrap at P-1, last_tick and half-period strobes. The encoder top holds the handshake, latch and coding logic.

Test Plan:
- Rate 0, Manchester: preload 1, en high, then stream 0.
  -> encoded_data is 1 for 64 cycles, then 0 for 64, then 0 for 64, then 1 for 64.
  -> lm_out toggles every 8 cycles only while encoded_data=1.
  -> last_tick is seen at count 127.
- Rate 3, BPSK, bits 1,0: encoded_data is 1 for 16 cycles, then 0 for 16. lm_out pattern is 8 high/8 low, then 8 low/8 high (phase flip at the bit boundary).
- Underrun: rate 2 (P=32), preload one bit, keep data_valid low.
  -> underrun pulses at the second period start.
  -> encoded_data=lm_out=0 for 32 cycles.
  -> a bit supplied afterwards is sent at the following period start.
- Handshake: hold full, data_valid held high.
  -> data_ready=0 until the count==0 consume.
  -> data_ready=1 for exactly one cycle, and the next bit is accepted.
  -> no bit is lost or duplicated over a 64-bit random stream.
- Change rate from 0 to 1 while en=1: the period stays 128 until en falls. After en rises again the period is 64.
- Abort: drop en at count 40, then assert rst_n=0 mid-period on a later run.
  -> outputs are 0 from the next cycle.
  -> hold is preserved through en low and cleared by reset (data_ready=1).
